// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data cache controller.
//   MEM_DEPTH / ADDR_W : dataram word-address depth and the line-address width.
//   state_e            : controller FSM encoding (2 bits).
//   req_t              : request captured on a miss or write.
//   sel_word()         : pick a 32-bit word out of a 128-bit line (word 0 = [31:0]).
package dcache_pkg;

    localparam int MEM_DEPTH = 12;
    localparam int ADDR_W    = MEM_DEPTH - 2;
    localparam int LINE_W    = 128;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MISS_RD = 2'd1,
        S_FILL    = 2'd2,
        S_WRITE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        offset;
        logic [31:0]       din;
        logic              hit;
    } req_t;

    function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line,
                                             input logic [1:0]        off);
        return line[{off, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/dcache_tagram.sv
// dcache_tagram: valid/tag/data storage for a direct-mapped cache.
//   clk_i, rst_ni      : clock, async active-low reset (clears valid bits only).
//   rd_idx_i           : combinational read index.
//   rd_valid_o/rd_tag_o/rd_line_o : contents of the indexed line.
//   wr_en_i            : write strobe.
//   wr_fill_i          : 1 = whole-line fill (sets tag and valid), 0 = word merge.
//   wr_idx_i, wr_tag_i, wr_line_i, wr_offset_i, wr_word_i : write data.
module dcache_tagram
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_W-1:0]     rd_line_o,
    input  logic                  wr_en_i,
    input  logic                  wr_fill_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [LINE_W-1:0]     wr_line_i,
    input  logic [1:0]            wr_offset_i,
    input  logic [31:0]           wr_word_i
);

    localparam int NLINES = 2 ** INDEX_BITS;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i && wr_fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_fill_i) begin
                tag_q[wr_idx_i]  <= wr_tag_i;
                data_q[wr_idx_i] <= wr_line_i;
            end else begin
                data_q[wr_idx_i][{wr_offset_i, 5'b0} +: 32] <= wr_word_i;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// between the pipeline memory stage and dataram.
//   clk_i, rst_ni                        : clock, async active-low reset.
//   cpu_re_i/cpu_we_i                    : load/store request, held until cpu_complete_o.
//   cpu_addr_i/cpu_offset_i/cpu_din_i    : line address, word in line, store data.
//   cpu_dout_o/cpu_complete_o            : load data and request-finished flag.
//   mem_re_o/mem_we_o/mem_addr_o/mem_offset_o/mem_din_o : to dataram.
//   mem_dout_i/mem_complete_i            : from dataram.
//   hit_count_o/miss_count_o             : read hit / miss counters (wrap).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_re_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [1:0]        cpu_offset_i,
    input  logic [31:0]       cpu_din_i,
    output logic [31:0]       cpu_dout_o,
    output logic              cpu_complete_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_offset_o,
    output logic [31:0]       mem_din_o,
    input  logic [LINE_W-1:0] mem_dout_i,
    input  logic              mem_complete_i,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
);

    localparam int TAG_W = ADDR_W - INDEX_BITS;

    state_e      state_q;
    req_t        req_q;
    logic        mem_re_q, mem_we_q;
    logic [31:0] hit_q, miss_q;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  wr_en, wr_fill;

    dcache_tagram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_tagram (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_idx_i    (cpu_addr_i[INDEX_BITS-1:0]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .wr_en_i     (wr_en),
        .wr_fill_i   (wr_fill),
        .wr_idx_i    (req_q.addr[INDEX_BITS-1:0]),
        .wr_tag_i    (req_q.addr[ADDR_W-1:INDEX_BITS]),
        .wr_line_i   (mem_dout_i),
        .wr_offset_i (req_q.offset),
        .wr_word_i   (req_q.din)
    );

    assign hit = rd_valid && (rd_tag == cpu_addr_i[ADDR_W-1:INDEX_BITS]);

    // Fill in FILL; word merge only when the store hit at request time.
    assign wr_fill = (state_q == S_FILL);
    assign wr_en   = wr_fill ||
                     ((state_q == S_WRITE) && mem_complete_i && req_q.hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // re & we together is treated as a store.
                    if (cpu_we_i) begin
                        req_q    <= '{addr: cpu_addr_i, offset: cpu_offset_i,
                                      din: cpu_din_i, hit: hit};
                        mem_we_q <= 1'b1;
                        state_q  <= S_WRITE;
                    end else if (cpu_re_i) begin
                        if (hit) begin
                            hit_q <= hit_q + 32'd1;
                        end else begin
                            req_q    <= '{addr: cpu_addr_i, offset: cpu_offset_i,
                                          din: 32'd0, hit: 1'b0};
                            miss_q   <= miss_q + 32'd1;
                            mem_re_q <= 1'b1;
                            state_q  <= S_MISS_RD;
                        end
                    end
                end
                S_MISS_RD: begin
                    if (mem_complete_i) begin
                        mem_re_q <= 1'b0;
                        state_q  <= S_FILL;
                    end
                end
                S_FILL: begin
                    state_q <= S_IDLE;
                end
                S_WRITE: begin
                    if (mem_complete_i) begin
                        mem_we_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_complete_o = 1'b1;
        cpu_dout_o     = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (cpu_we_i) begin
                    cpu_complete_o = 1'b0;
                end else if (cpu_re_i) begin
                    cpu_complete_o = hit;
                    if (hit) cpu_dout_o = sel_word(rd_line, cpu_offset_i);
                end
            end
            S_MISS_RD: cpu_complete_o = 1'b0;
            // dataram's dout settled one clk after mem_complete; forward it directly.
            S_FILL:    cpu_dout_o = sel_word(mem_dout_i, req_q.offset);
            S_WRITE:   cpu_complete_o = mem_complete_i;
            default:   cpu_complete_o = 1'b1;
        endcase
    end

    assign mem_re_o     = mem_re_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = req_q.addr;
    assign mem_offset_o = req_q.offset;
    assign mem_din_o    = req_q.din;
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a behavioural dataram
// (mem_complete on the 21st cycle of a request, dout updated on that edge).
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int IB = 4;

    logic              clk, rst_n;
    logic              cpu_re, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_offset;
    logic [31:0]       cpu_din, cpu_dout;
    logic              cpu_complete;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_offset;
    logic [31:0]       mem_din;
    logic [127:0]      mem_dout;
    logic              mem_complete;
    logic [31:0]       hit_count, miss_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    dcache_ctrl #(.INDEX_BITS(IB)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_re_i(cpu_re), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_offset_i(cpu_offset), .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout),
        .cpu_complete_o(cpu_complete),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_offset_o(mem_offset), .mem_din_o(mem_din), .mem_dout_i(mem_dout),
        .mem_complete_i(mem_complete),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial contents of a word in the dataram model.
    function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a, input logic [1:0] o);
        return 32'hA000_0000 | (32'(a) << 4) | 32'(o);
    endfunction

    // ---------------- dataram model ----------------
    logic [127:0] dmem [1024];
    logic [127:0] dout_q;
    int           dcnt;
    assign mem_complete = (mem_re || mem_we) && (dcnt == 20);
    assign mem_dout     = dout_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt   <= 0;
            dout_q <= '0;
            for (int i = 0; i < 1024; i++)
                for (int w = 0; w < 4; w++)
                    dmem[i][w*32 +: 32] <= pat(ADDR_W'(i), 2'(w));
            dmem[16] <= {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        end else if (mem_re || mem_we) begin
            if (dcnt == 20) begin
                dcnt <= 0;
                if (mem_we) dmem[mem_addr][{mem_offset, 5'b0} +: 32] <= mem_din;
                else        dout_q <= dmem[mem_addr];
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            dcnt <= 0;
        end
    end

    // Runs one held request; returns completion cycle and mem_re/mem_we cycle counts.
    task automatic run_req(output int cyc, output int rc, output int wc, output logic both);
        cyc = 0; rc = 0; wc = 0; both = 1'b0;
        #1;
        while (1) begin
            if (mem_re) rc++;
            if (mem_we) wc++;
            if (mem_re && mem_we) both = 1'b1;
            if (cpu_complete || cyc >= 100) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [1:0] o,
                           input logic [31:0] expd, input int exp_lat, input string nm);
        int cyc, rc, wc; logic both; logic [31:0] got, e;
        exp_q.push_back(expd);
        cpu_addr = a; cpu_offset = o; cpu_re = 1'b1; cpu_we = 1'b0;
        run_req(cyc, rc, wc, both);
        got = cpu_dout;
        total++;
        if (cyc !== exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_lat);
        end
        total++;
        if (rc !== (exp_lat == 0 ? 0 : 21) || wc !== 0 || both) begin
            bad++; $display("FAIL %s mem_re cycles: got re=%0d we=%0d want re=%0d we=0",
                            nm, rc, wc, (exp_lat == 0 ? 0 : 21));
        end
        total++;
        e = exp_q.pop_front();
        if (got !== e) begin
            bad++; $display("FAIL %s dout: got %h want %h", nm, got, e);
        end
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [1:0] o,
                            input logic [31:0] d, input logic also_re, input string nm);
        int cyc, rc, wc; logic both;
        cpu_addr = a; cpu_offset = o; cpu_din = d; cpu_we = 1'b1; cpu_re = also_re;
        run_req(cyc, rc, wc, both);
        total++;
        if (cyc !== 21) begin
            bad++; $display("FAIL %s latency: got %0d want 21", nm, cyc);
        end
        total++;
        if (wc !== 21 || rc !== 0 || both) begin
            bad++; $display("FAIL %s mem_we cycles: got we=%0d re=%0d want we=21 re=0", nm, wc, rc);
        end
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
    endtask

    task automatic test_reset();
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_offset = '0; cpu_din = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cpu_complete !== 1'b1 || cpu_dout !== 32'd0) begin
            bad++; $display("FAIL reset cpu: got complete=%b dout=%h want 1/0", cpu_complete, cpu_dout);
        end
        total++;
        if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL reset mem: got re=%b we=%b want 0/0", mem_re, mem_we);
        end
        total++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            bad++; $display("FAIL reset counters: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_miss_then_hit();
        do_read(10'h10, 2'd2, 32'hCCCC, 22, "first_miss");
        total++;
        if (miss_count !== 32'd1) begin
            bad++; $display("FAIL miss_count after miss: got %0d want 1", miss_count);
        end
        do_read(10'h10, 2'd2, 32'hCCCC, 0, "repeat_hit");
        total++;
        if (hit_count !== 32'd1) begin
            bad++; $display("FAIL hit_count after hit: got %0d want 1", hit_count);
        end
    endtask

    task automatic test_write_hit();
        do_write(10'h10, 2'd0, 32'h1234_5678, 1'b0, "write_hit");
        do_read(10'h10, 2'd0, 32'h1234_5678, 0, "read_after_write_hit");
        do_read(10'h10, 2'd1, 32'hBBBB, 0, "neighbour_word_kept");
    endtask

    task automatic test_write_miss();
        logic [31:0] m0;
        m0 = miss_count;
        do_write(10'h25, 2'd1, 32'hCAFE_F00D, 1'b0, "write_miss");
        do_read(10'h25, 2'd1, 32'hCAFE_F00D, 22, "read_after_write_miss");
        total++;
        if (miss_count - m0 !== 32'd1) begin
            bad++; $display("FAIL no_allocate miss delta: got %0d want 1", miss_count - m0);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] m0;
        m0 = miss_count;
        do_read(10'h03, 2'd0, pat(10'h03, 2'd0), 22, "conflict_a");
        do_read(10'h13, 2'd3, pat(10'h13, 2'd3), 22, "conflict_b");
        do_read(10'h03, 2'd1, pat(10'h03, 2'd1), 22, "conflict_a_again");
        total++;
        if (miss_count - m0 !== 32'd3) begin
            bad++; $display("FAIL conflict miss delta: got %0d want 3", miss_count - m0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h0;
        h0 = hit_count;
        for (int w = 0; w < 4; w++)
            do_read(10'h03, 2'(w), pat(10'h03, 2'(w)), 0, "b2b_hit");
        total++;
        if (hit_count - h0 !== 32'd4) begin
            bad++; $display("FAIL b2b hit delta: got %0d want 4", hit_count - h0);
        end
    endtask

    task automatic test_illegal_re_we();
        logic [31:0] h0, m0;
        h0 = hit_count; m0 = miss_count;
        do_write(10'h03, 2'd2, 32'h0BAD_BEEF, 1'b1, "re_we_as_write");
        total++;
        if (hit_count !== h0 || miss_count !== m0) begin
            bad++; $display("FAIL re_we counters: got %0d/%0d want %0d/%0d", hit_count, miss_count, h0, m0);
        end
        do_read(10'h03, 2'd2, 32'h0BAD_BEEF, 0, "re_we_merged");
    endtask

    task automatic test_reset_mid_miss();
        cpu_addr = 10'h07; cpu_offset = 2'd0; cpu_re = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (mem_re !== 1'b1) begin
            bad++; $display("FAIL mid_miss mem_re before reset: got %b want 1", mem_re);
        end
        cpu_re = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_re !== 1'b0 || cpu_complete !== 1'b1 || miss_count !== 32'd0) begin
            bad++; $display("FAIL mid_miss reset: got re=%b complete=%b miss=%0d want 0/1/0",
                            mem_re, cpu_complete, miss_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(10'h07, 2'd0, pat(10'h07, 2'd0), 22, "read_after_abort");
        do_read(10'h10, 2'd2, 32'hCCCC, 22, "valid_cleared");
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_back_to_back();
        test_illegal_re_we();
        test_reset_mid_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache between the MIPS pipeline's memory stage and `dataram`. It consumes `dataram`'s 128-bit line reads and forwards word writes to it. Read hits complete in the request cycle. Misses and all writes stall the pipeline through the same `complete` handshake that `dataram` uses.

## Interface
- `INDEX_BITS`, default 4: number of cache lines is 2**INDEX_BITS.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_re`  in  1  load request; held until `cpu_complete`.
- `cpu_we`  in  1  store request; held until `cpu_complete`.
- `cpu_addr`  in  `MEM_DEPTH`-2  line address.
- `cpu_offset`  in  2  word within line.
- `cpu_din`  in  32  store data.
- `cpu_dout`  out  32  load data; valid when `cpu_complete` and `cpu_re`.
- `cpu_complete`  out  1  request finished; 1 when idle.
- `mem_re`  out  1  to `dataram.re`.
- `mem_we`  out  1  to `dataram.we`.
- `mem_addr`  out  `MEM_DEPTH`-2  to `dataram.addr`.
- `mem_offset`  out  2  to `dataram.offset`.
- `mem_din`  out  32  to `dataram.din`.
- `mem_dout`  in  128  from `dataram.dout`.
- `mem_complete`  in  1  from `dataram.complete`.
- `hit_count`  out  32  read hits since reset; wraps.
- `miss_count`  out  32  read misses since reset; wraps.

## Operation
- Address split:
  - index = `cpu_addr[INDEX_BITS-1:0]`.
  - tag = remaining upper bits of `cpu_addr`.
  - `cpu_offset` selects the 32-bit word; word 0 = bits [31:0].
- Per line: valid bit, tag, 128-bit data.
- Hit = valid[index] & (tag[index] == tag).
- FSM states: IDLE, MISS_RD, FILL, WRITE.
- IDLE:
  - `cpu_re` & hit: `cpu_dout` = the cached word (combinational). `cpu_complete`=1. `hit_count`++. Stay in IDLE.
  - `cpu_re` & miss: register addr/offset, `miss_count`++, go to MISS_RD.
  - `cpu_we`: register addr/offset/din and the hit flag, go to WRITE. Writes are not counted.
  - `cpu_re` & `cpu_we` together is illegal. The block treats it as a write.
- MISS_RD:
  - `mem_re`=1 with the registered addr.
  - On `mem_complete`, go to FILL.
- FILL:
  - Capture `mem_dout` into data[index].
  - Set tag[index] and valid[index].
  - Drive `cpu_dout` from the selected word of `mem_dout`.
  - `cpu_complete`=1.
  - Return to IDLE.
- WRITE:
  - `mem_we`=1 with the registered addr/offset/din.
  - On `mem_complete`: `cpu_complete`=1. If the registered hit flag is set, merge din into the cached word at offset. Return to IDLE.
  - A miss does not allocate.
- `cpu_complete` = 0 in MISS_RD, in WRITE before `mem_complete`, and in IDLE when a request misses or is a write. It is 1 in all other cases.
- `mem_re` and `mem_we` are never asserted together. Both are 0 in IDLE and FILL.

## Timing
- Reset:
  - state = IDLE; all valid bits = 0.
  - `mem_re` = `mem_we` = 0.
  - `hit_count` = `miss_count` = 0.
  - `cpu_complete` = 1; `cpu_dout` = 0.
  - Tags and data are not reset.
- Reset asserted mid-operation aborts the transaction. `dataram` resets from the same source, so no partial write lands.
- Read hit: 0 stall cycles.
- Read miss, with `dataram` asserting `mem_complete` on its L+1-th cycle of `mem_re` (L = `MEM_LATENCY` = 20):
  - 1 IDLE cycle + 21 MISS_RD cycles + 1 FILL cycle.
  - `cpu_complete` rises in cycle 22, counting from the request cycle as 0.
- Write, hit or miss: 1 IDLE cycle + 21 WRITE cycles. `cpu_complete` is asserted in cycle 21.
- `mem_dout` is sampled only in FILL, one clk after `mem_complete`. This covers `dataram` updating `dout` on `memclk`.
- A new request may be presented in the cycle after `cpu_complete`. Back-to-back hits complete every cycle.
- A miss to line X followed immediately by a read of X hits.

## Structure
- Shared defines header (`mips_defines.v`):
  - FSM state encodings (2 bits).
  - `MEM_DEPTH`.
- Sub-module `dcache_tagram`:
  - valid/tag/data arrays.
  - Combinational read port by index.
  - One write port with line-fill and word-merge modes.
  - Asynchronous valid clear.
- `dcache_ctrl` holds the FSM, request registers, counters and output muxing.

## Test plan
- After reset, read addr 0x10 offset 2 (memory line = 0x...DDDD_CCCC_BBBB_AAAA) -> `mem_re` high for 21 cycles, `cpu_complete` in cycle 22, `cpu_dout`=0xCCCC, `miss_count`=1.
- Repeat the same read -> `cpu_complete` same cycle, `cpu_dout`=0xCCCC, `mem_re` never asserted, `hit_count`=1.
- Write 0x12345678 to the cached line offset 0 -> `mem_we` for 21 cycles. A following read offset 0 hits and returns 0x12345678.
- Write to an uncached addr, then read it -> write completes in cycle 21. The read misses (no allocate) and returns the written value from `dataram`.
- Conflict: read addr A, then A + 2**INDEX_BITS, then A -> three misses, `miss_count`=3.
- Assert `rst` low in the middle of MISS_RD -> `mem_re`=0 immediately, state IDLE. The next read of the same addr misses.
